// File: rtl/polilock_pkg.sv
// Shared types and constants for the Polilock password engine.
package polilock_pkg;

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    ESPERA_CMD   = 4'd1,
    ESPERA_SLOT  = 4'd2,
    RECEBE_SENHA = 4'd3,
    RECEBE_NOVA  = 4'd4,
    GRAVA        = 4'd5,
    RESULTADO    = 4'd6,
    BLOQUEADO    = 4'd7
  } estado_t;

  localparam logic [7:0] CMD_VERIFICA = 8'h76;
  localparam logic [7:0] CMD_MEMORIZA = 8'h6D;
  localparam logic [7:0] CHAR_ZERO    = 8'h30;

endpackage

// File: rtl/polilock_banco_senhas.sv
// Password register bank: combinational read of one character, atomic whole-slot write.
module polilock_banco_senhas #(
  parameter int N_CHARS = 10,
  parameter int N_SLOTS = 4,
  parameter int SLOT_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
  parameter int IDX_W   = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SLOT_W-1:0]      slot_rd,
  input  logic [IDX_W-1:0]       idx_rd,
  output logic [7:0]             char_rd,
  input  logic                   grava,
  input  logic [SLOT_W-1:0]      slot_wr,
  input  logic [N_CHARS*8-1:0]   senha_wr
);
  import polilock_pkg::*;

  logic [7:0] mem [N_SLOTS][N_CHARS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < N_SLOTS; s++)
        for (int c = 0; c < N_CHARS; c++)
          mem[s][c] <= CHAR_ZERO;
    end else if (grava) begin
      for (int c = 0; c < N_CHARS; c++)
        mem[slot_wr][c] <= senha_wr[c*8 +: 8];
    end
  end

  assign char_rd = mem[slot_rd][idx_rd];

endmodule

// File: rtl/polilock_verificador.sv
// Polilock password engine: command parsing, streaming compare, reprogramming,
// inter-byte timeout and lockout after repeated failures.
//
//   state        | meaning
//   OCIOSO       | idle, waiting for iniciar
//   ESPERA_CMD   | waiting for 'v' / 'm'
//   ESPERA_SLOT  | waiting for slot digit
//   RECEBE_SENHA | receiving (old) password, compared char by char
//   RECEBE_NOVA  | buffering new password
//   GRAVA        | committing new password to the bank
//   RESULTADO    | one-cycle result, decides lockout
//   BLOQUEADO    | lockout timer running, all input ignored
module polilock_verificador #(
  parameter int N_CHARS        = 10,
  parameter int N_SLOTS        = 4,
  parameter int MAX_ERROS      = 3,
  parameter int LOCK_CICLOS    = 50_000_000,
  parameter int TIMEOUT_CICLOS = 250_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] dado,
  input  logic       dado_valido,
  output logic       acertou,
  output logic       errou,
  output logic       gravou,
  output logic       bloqueado,
  output logic       ocupado,
  output logic [3:0] db_estado
);
  import polilock_pkg::*;

  localparam int IDX_W  = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int ERR_W  = $clog2(MAX_ERROS + 1);
  localparam int LOCK_W = $clog2(LOCK_CICLOS);
  localparam int TMO_W  = $clog2(TIMEOUT_CICLOS);

  localparam logic [IDX_W-1:0]  IDX_ULTIMO  = IDX_W'(N_CHARS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = ERR_W'(MAX_ERROS);
  localparam logic [LOCK_W-1:0] LOCK_INI    = LOCK_W'(LOCK_CICLOS - 1);
  localparam logic [TMO_W-1:0]  TMO_INI     = TMO_W'(TIMEOUT_CICLOS - 1);
  localparam logic [7:0]        SLOT_LIMITE = CHAR_ZERO + 8'(N_SLOTS);

  estado_t               estado, estado_nxt;
  logic                  cmd_mem, cmd_mem_nxt;
  logic [SLOT_W-1:0]     slot_sel, slot_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic                  mismatch, mismatch_nxt;
  logic [N_CHARS*8-1:0]  nova, nova_nxt;
  logic [ERR_W-1:0]      erros, erros_nxt, erros_inc;
  logic [LOCK_W-1:0]     lock_cnt, lock_nxt;
  logic [TMO_W-1:0]      tmo_cnt, tmo_nxt;
  logic                  acertou_nxt, errou_nxt, gravou_nxt, bloqueado_nxt;
  logic                  armar, conta_erro, grava, esperando, mm;
  logic [7:0]            char_slot;

  polilock_banco_senhas #(
    .N_CHARS (N_CHARS),
    .N_SLOTS (N_SLOTS),
    .SLOT_W  (SLOT_W),
    .IDX_W   (IDX_W)
  ) u_banco (
    .clock    (clock),
    .reset    (reset),
    .slot_rd  (slot_sel),
    .idx_rd   (idx),
    .char_rd  (char_slot),
    .grava    (grava),
    .slot_wr  (slot_sel),
    .senha_wr (nova)
  );

  always_comb begin
    estado_nxt    = estado;
    cmd_mem_nxt   = cmd_mem;
    slot_nxt      = slot_sel;
    idx_nxt       = idx;
    mismatch_nxt  = mismatch;
    nova_nxt      = nova;
    erros_nxt     = erros;
    erros_inc     = (erros == ERR_MAX) ? erros : erros + ERR_W'(1);
    lock_nxt      = lock_cnt;
    tmo_nxt       = (tmo_cnt == '0) ? tmo_cnt : tmo_cnt - TMO_W'(1);
    acertou_nxt   = acertou;
    errou_nxt     = errou;
    gravou_nxt    = gravou;
    bloqueado_nxt = bloqueado;
    armar         = 1'b0;
    conta_erro    = 1'b0;
    grava         = 1'b0;
    mm            = mismatch | (dado != char_slot);
    esperando     = (estado inside {ESPERA_CMD, ESPERA_SLOT, RECEBE_SENHA, RECEBE_NOVA});

    // Lockout timer runs independently of the state so bloqueado spans exactly LOCK_CICLOS.
    if (bloqueado) begin
      if (lock_cnt == '0) begin
        bloqueado_nxt = 1'b0;
        erros_nxt     = '0;
      end else begin
        lock_nxt = lock_cnt - LOCK_W'(1);
      end
    end

    if (esperando && iniciar) begin
      armar = 1'b1;
    end else if (esperando && tmo_cnt == '0) begin
      errou_nxt  = 1'b1;
      estado_nxt = OCIOSO;
    end else begin
      case (estado)
        OCIOSO: if (iniciar) armar = 1'b1;
        ESPERA_CMD: if (dado_valido) begin
          tmo_nxt = TMO_INI;
          if (dado == CMD_VERIFICA || dado == CMD_MEMORIZA) begin
            cmd_mem_nxt = (dado == CMD_MEMORIZA);
            estado_nxt  = ESPERA_SLOT;
          end else begin
            errou_nxt  = 1'b1;
            estado_nxt = OCIOSO;
          end
        end
        ESPERA_SLOT: if (dado_valido) begin
          tmo_nxt = TMO_INI;
          if (dado >= CHAR_ZERO && dado < SLOT_LIMITE) begin
            slot_nxt     = SLOT_W'(dado - CHAR_ZERO);
            idx_nxt      = '0;
            mismatch_nxt = 1'b0;
            estado_nxt   = RECEBE_SENHA;
          end else begin
            errou_nxt  = 1'b1;
            estado_nxt = OCIOSO;
          end
        end
        RECEBE_SENHA: if (dado_valido) begin
          tmo_nxt = TMO_INI;
          if (idx == IDX_ULTIMO) begin
            if (cmd_mem && !mm) begin
              idx_nxt    = '0;
              estado_nxt = RECEBE_NOVA;
            end else begin
              estado_nxt = RESULTADO;
              if (mm) begin
                errou_nxt  = 1'b1;
                conta_erro = 1'b1;
              end else begin
                acertou_nxt = 1'b1;
                erros_nxt   = '0;
              end
            end
          end else begin
            idx_nxt      = idx + IDX_W'(1);
            mismatch_nxt = mm;
          end
        end
        RECEBE_NOVA: if (dado_valido) begin
          tmo_nxt = TMO_INI;
          nova_nxt[int'(idx)*8 +: 8] = dado;
          if (idx == IDX_ULTIMO) estado_nxt = GRAVA;
          else                   idx_nxt    = idx + IDX_W'(1);
        end
        GRAVA: begin
          grava      = 1'b1;
          gravou_nxt = 1'b1;
          erros_nxt  = '0;
          estado_nxt = RESULTADO;
        end
        RESULTADO: begin
          if (bloqueado && lock_cnt != '0) estado_nxt = BLOQUEADO;
          else if (iniciar)                armar      = 1'b1;
          else                             estado_nxt = OCIOSO;
        end
        BLOQUEADO: if (!bloqueado || lock_cnt == '0) estado_nxt = OCIOSO;
        default: estado_nxt = OCIOSO;
      endcase
    end

    if (conta_erro) begin
      erros_nxt = erros_inc;
      if (erros_inc == ERR_MAX) begin
        bloqueado_nxt = 1'b1;
        lock_nxt      = LOCK_INI;
      end
    end

    if (armar) begin
      estado_nxt  = ESPERA_CMD;
      acertou_nxt = 1'b0;
      errou_nxt   = 1'b0;
      gravou_nxt  = 1'b0;
      tmo_nxt     = TMO_INI;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      cmd_mem   <= 1'b0;
      slot_sel  <= '0;
      idx       <= '0;
      mismatch  <= 1'b0;
      nova      <= '0;
      erros     <= '0;
      lock_cnt  <= '0;
      tmo_cnt   <= '0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      gravou    <= 1'b0;
      bloqueado <= 1'b0;
    end else begin
      estado    <= estado_nxt;
      cmd_mem   <= cmd_mem_nxt;
      slot_sel  <= slot_nxt;
      idx       <= idx_nxt;
      mismatch  <= mismatch_nxt;
      nova      <= nova_nxt;
      erros     <= erros_nxt;
      lock_cnt  <= lock_nxt;
      tmo_cnt   <= tmo_nxt;
      acertou   <= acertou_nxt;
      errou     <= errou_nxt;
      gravou    <= gravou_nxt;
      bloqueado <= bloqueado_nxt;
    end
  end

  assign ocupado   = (estado != OCIOSO) && (estado != BLOQUEADO);
  assign db_estado = estado;

endmodule
